wb_result_stage: RTL and testbench

Parametrised, registered writeback stage for the CPU pipeline. It sits between the MEM/WB boundary and the register file. Each cycle it picks one of NSRC result sources by one-hot select, and aligns and sign/zero-extends load data for sub-word loads. It buffers results in a two-entry skid buffer behind a valid/ready handshake. At commit it drives the register-file write port and the debug trace signals.

---
 rtl/wb_result_stage.sv | 153 +++++++++++++++
 tb/tb_wb_result_stage.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_stage.sv
// Writeback result stage: one-hot source select with load align/extend, a two-entry skid
// buffer behind valid/ready, and the register-file commit and debug trace ports.
module wb_result_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSRC   = 5,
  parameter int unsigned RF_AW  = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NSRC-1:0]              in_src_sel,
  input  logic [NSRC*DATA_W-1:0]       in_src_data,
  input  logic [1:0]                   in_mem_size,
  input  logic                         in_mem_signed,
  input  logic [$clog2(DATA_W/8)-1:0]  in_addr_lo,
  input  logic                         in_rf_wen,
  input  logic [RF_AW-1:0]             in_rf_waddr,
  input  logic [31:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         rf_we,
  output logic [RF_AW-1:0]             rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [31:0]                  debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_wen,
  output logic [RF_AW-1:0]             debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata
);

  localparam int unsigned LoW      = $clog2(DATA_W / 8);
  // Only a 64-bit datapath has two word lanes.
  localparam int unsigned WordMask = (DATA_W == 64) ? 4 : 0;

  logic [DATA_W-1:0] other_data, mem_data, shifted, load_tmp, load_data, result;
  logic [LoW-1:0]    lane;
  logic [LoW+2:0]    shamt;
  int unsigned       keep_w;

  always_comb begin
    other_data = '0;
    // Descending scan so the lowest set index is the last assignment and wins.
    for (int k = NSRC - 1; k >= 1; k--) begin
      if (in_src_sel[k]) other_data = in_src_data[k*DATA_W +: DATA_W];
    end

    mem_data = in_src_data[DATA_W-1:0];
    keep_w   = DATA_W;
    lane     = '0;
    case (in_mem_size)
      2'd0: begin keep_w = 8;  lane = in_addr_lo;                end
      2'd1: begin keep_w = 16; lane = in_addr_lo & ~LoW'(1);     end
      2'd2: begin keep_w = 32; lane = in_addr_lo & LoW'(WordMask); end
      default: begin keep_w = 64; lane = '0; end
    endcase
    if (keep_w > DATA_W) keep_w = DATA_W;

    shamt    = {lane, 3'b000};
    shifted  = mem_data >> shamt;
    // Park the field at the MSB, then shift back down to zero- or sign-fill.
    load_tmp = shifted << (DATA_W - keep_w);
    if (in_mem_signed) load_data = DATA_W'($signed(load_tmp) >>> (DATA_W - keep_w));
    else               load_data = load_tmp >> (DATA_W - keep_w);

    result = in_src_sel[0] ? load_data : other_data;
  end

  logic              head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] head_res_q, head_res_d, skid_res_q, skid_res_d;
  logic              head_wen_q, head_wen_d, skid_wen_q, skid_wen_d;
  logic [RF_AW-1:0]  head_waddr_q, head_waddr_d, skid_waddr_q, skid_waddr_d;
  logic [31:0]       head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic              accept, pop;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = head_valid_q & out_ready;

  always_comb begin
    head_valid_d = head_valid_q;
    head_res_d   = head_res_q;
    head_wen_d   = head_wen_q;
    head_waddr_d = head_waddr_q;
    head_pc_d    = head_pc_q;
    skid_valid_d = skid_valid_q;
    skid_res_d   = skid_res_q;
    skid_wen_d   = skid_wen_q;
    skid_waddr_d = skid_waddr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      head_res_d   = skid_res_q;
      head_wen_d   = skid_wen_q;
      head_waddr_d = skid_waddr_q;
      head_pc_d    = skid_pc_q;
      skid_valid_d = 1'b0;
    end else if (accept && (pop || !head_valid_q)) begin
      head_valid_d = 1'b1;
      head_res_d   = result;
      head_wen_d   = in_rf_wen;
      head_waddr_d = in_rf_waddr;
      head_pc_d    = in_pc;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_res_d   = result;
      skid_wen_d   = in_rf_wen;
      skid_waddr_d = in_rf_waddr;
      skid_pc_d    = in_pc;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_valid_q <= 1'b0;
      head_res_q   <= '0;
      head_wen_q   <= 1'b0;
      head_waddr_q <= '0;
      head_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_res_q   <= '0;
      skid_wen_q   <= 1'b0;
      skid_waddr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_res_q   <= head_res_d;
      head_wen_q   <= head_wen_d;
      head_waddr_q <= head_waddr_d;
      head_pc_q    <= head_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_res_q   <= skid_res_d;
      skid_wen_q   <= skid_wen_d;
      skid_waddr_q <= skid_waddr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid         = head_valid_q;
  assign rf_we             = pop & head_wen_q & !flush;
  assign rf_waddr          = head_waddr_q;
  assign rf_wdata          = head_res_q;
  assign debug_wb_pc       = head_pc_q;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = head_waddr_q;
  assign debug_wb_rf_wdata = head_res_q;

endmodule

// File: tb/tb_wb_result_stage.sv
// Self-checking bench for wb_result_stage: directed scenarios on 32- and 64-bit instances
// plus a randomized stream checked against a transaction-level queue model.
module tb_wb_result_stage;

  logic         clock, reset, flush, in_valid, in_ready, in_mem_signed, in_rf_wen;
  logic [4:0]   in_src_sel, in_rf_waddr, rf_waddr, debug_wb_rf_wnum;
  logic [159:0] in_src_data;
  logic [1:0]   in_mem_size, in_addr_lo;
  logic [31:0]  in_pc, rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic         out_valid, out_ready, rf_we;
  logic [3:0]   debug_wb_rf_wen;

  logic         x_in_valid, x_in_ready, x_signed, x_out_valid, x_rf_we;
  logic [4:0]   x_src_sel, x_rf_waddr, x_dbg_wnum;
  logic [319:0] x_src_data;
  logic [1:0]   x_size;
  logic [2:0]   x_addr_lo;
  logic [63:0]  x_rf_wdata, x_dbg_wdata;
  logic [31:0]  x_dbg_pc;
  logic [3:0]   x_dbg_wen;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] pc;
  } ent_t;

  wb_result_stage #(.DATA_W(32), .NSRC(5), .RF_AW(5)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_src_sel(in_src_sel), .in_src_data(in_src_data), .in_mem_size(in_mem_size),
    .in_mem_signed(in_mem_signed), .in_addr_lo(in_addr_lo), .in_rf_wen(in_rf_wen),
    .in_rf_waddr(in_rf_waddr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  wb_result_stage #(.DATA_W(64), .NSRC(5), .RF_AW(5)) dut64 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .in_src_sel(x_src_sel), .in_src_data(x_src_data), .in_mem_size(x_size),
    .in_mem_signed(x_signed), .in_addr_lo(x_addr_lo), .in_rf_wen(in_rf_wen),
    .in_rf_waddr(in_rf_waddr), .in_pc(in_pc), .out_valid(x_out_valid), .out_ready(out_ready),
    .rf_we(x_rf_we), .rf_waddr(x_rf_waddr), .rf_wdata(x_rf_wdata), .debug_wb_pc(x_dbg_pc),
    .debug_wb_rf_wen(x_dbg_wen), .debug_wb_rf_wnum(x_dbg_wnum),
    .debug_wb_rf_wdata(x_dbg_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int first_set(logic [4:0] s);
    for (int k = 0; k < 5; k++) if (s[k]) return k;
    return -1;
  endfunction

  // Load result from the raw memory word: pick the aligned lane, mask to size, extend.
  function automatic logic [63:0] ref_load(logic [63:0] mem, int size, bit sgn, int off, int dw);
    int bits, lane;
    logic [63:0] v, mask;
    bits = 8 << size;
    if (bits > dw) bits = dw;
    lane = (bits == dw) ? 0 : off - (off % (bits / 8));
    v = mem >> (lane * 8);
    if (bits < 64) begin
      mask = (64'd1 << bits) - 64'd1;
      v = v & mask;
      if (sgn && v[bits-1]) v = v | ~mask;
    end
    if (dw == 32) v = {32'h0, v[31:0]};
    return v;
  endfunction

  task automatic drive(logic [4:0] sel, logic [159:0] src, int size, bit sgn, int off,
                       logic [4:0] waddr, logic [31:0] pc);
    in_valid      = 1'b1;
    in_src_sel    = sel;
    in_src_data   = src;
    in_mem_size   = 2'(size);
    in_mem_signed = sgn;
    in_addr_lo    = 2'(off);
    in_rf_wen     = 1'b1;
    in_rf_waddr   = waddr;
    in_pc         = pc;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_in_valid = 1'b0;
    in_src_sel = '0; in_src_data = '0; in_mem_size = '0; in_mem_signed = 1'b0; in_addr_lo = '0;
    in_rf_wen = 1'b0; in_rf_waddr = '0; in_pc = '0;
    x_src_sel = '0; x_src_data = '0; x_size = '0; x_signed = 1'b0; x_addr_lo = '0;
    repeat (2) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin
      bad++; $display("FAIL rst_we: got %b/%h want 0/0", rf_we, debug_wb_rf_wen); end
    total++; if (rf_wdata !== 32'h0 || rf_waddr !== 5'h0 || debug_wb_pc !== 32'h0) begin
      bad++; $display("FAIL rst_fields: got %h/%h/%h want 0", rf_wdata, rf_waddr, debug_wb_pc); end
    total++; if (x_out_valid !== 1'b0 || x_rf_wdata !== 64'h0) begin
      bad++; $display("FAIL rst_x: got %b/%h want 0/0", x_out_valid, x_rf_wdata); end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    out_ready = 1'b1;
    drive(5'b01010, {32'h0, 32'h33333333, 32'h0, 32'h11111111, 32'h0}, 2, 1'b0, 0, 5'd7,
          32'h100);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || rf_wdata !== 32'h11111111) begin
      bad++; $display("FAIL prio_data: got %b/%h want 1/11111111", out_valid, rf_wdata); end
    total++; if (rf_we !== 1'b1 || debug_wb_rf_wen !== 4'hF) begin
      bad++; $display("FAIL prio_we: got %b/%h want 1/f", rf_we, debug_wb_rf_wen); end
    total++; if (rf_waddr !== 5'd7 || debug_wb_rf_wnum !== 5'd7 || debug_wb_pc !== 32'h100 ||
                 debug_wb_rf_wdata !== 32'h11111111) begin
      bad++; $display("FAIL prio_dbg: got %h/%h/%h/%h want 7/7/100/11111111", rf_waddr,
                      debug_wb_rf_wnum, debug_wb_pc, debug_wb_rf_wdata); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prio_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_load_ext();
    int          sz [3] = '{0, 1, 0};
    bit          sg [3] = '{1'b1, 1'b0, 1'b1};
    int          of [3] = '{2, 2, 0};
    logic [31:0] ex [3] = '{32'hFFFFFFF0, 32'h000080F0, 32'h00000001};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(5'b00001, {128'h0, 32'h80F07F01}, sz[i], sg[i], of[i], 5'd3, 32'h200);
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || rf_wdata !== ex[i]) begin
        bad++; $display("FAIL load_ext%0d: got %b/%h want 1/%h", i, out_valid, rf_wdata, ex[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] s;
    s = {128'h0, 32'hA};
    out_ready = 1'b1;
    drive(5'b00010, {96'h0, 32'hAAAA0001, 32'h0}, 2, 1'b0, 0, 5'd1, 32'h1000);
    tick();
    drive(5'b00010, {96'h0, 32'hBBBB0002, 32'h0}, 2, 1'b0, 0, 5'd2, 32'h1004);
    out_ready = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0 || rf_wdata !== 32'hAAAA0001) begin
      bad++; $display("FAIL b2b_stall1: got %b/%h want 0/aaaa0001", rf_we, rf_wdata); end
    tick();
    drive(5'b00010, {96'h0, 32'hCCCC0003, 32'h0}, 2, 1'b0, 0, 5'd3, 32'h1008);
    #1;
    total++; if (in_ready !== 1'b0 || rf_we !== 1'b0 || rf_wdata !== 32'hAAAA0001) begin
      bad++; $display("FAIL b2b_full: got %b/%b/%h want 0/0/aaaa0001", in_ready, rf_we, rf_wdata); end
    tick();
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0 || rf_we !== 1'b1 || rf_wdata !== 32'hAAAA0001 ||
                 debug_wb_pc !== 32'h1000) begin
      bad++; $display("FAIL b2b_a: got %b/%b/%h/%h want 0/1/aaaa0001/1000", in_ready, rf_we,
                      rf_wdata, debug_wb_pc); end
    tick();
    total++; if (in_ready !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'hBBBB0002 ||
                 rf_waddr !== 5'd2) begin
      bad++; $display("FAIL b2b_b: got %b/%b/%h/%h want 1/1/bbbb0002/2", in_ready, rf_we,
                      rf_wdata, rf_waddr); end
    tick();
    in_valid = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_wdata !== 32'hCCCC0003 || debug_wb_pc !== 32'h1008) begin
      bad++; $display("FAIL b2b_c: got %b/%h/%h want 1/cccc0003/1008", rf_we, rf_wdata,
                      debug_wb_pc); end
    tick();
    total++; if (out_valid !== 1'b0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL b2b_end: got %b/%b want 0/0", out_valid, rf_we); end
    in_src_data = s;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(5'b00010, {96'h0, 32'h0000F001, 32'h0}, 2, 1'b0, 0, 5'd4, 32'h2000);
    tick();
    drive(5'b00010, {96'h0, 32'h0000F002, 32'h0}, 2, 1'b0, 0, 5'd5, 32'h2004);
    tick();
    drive(5'b00010, {96'h0, 32'h0000F003, 32'h0}, 2, 1'b0, 0, 5'd6, 32'h2008);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    total++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin
      bad++; $display("FAIL flush_we: got %b/%h want 0/0", rf_we, debug_wb_rf_wen); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_empty: got %b/%b want 0/1", out_valid, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(5'b00100, {64'h0, 32'h12345678, 64'h0}, 2, 1'b0, 0, 5'd9, 32'h3000);
    tick();
    drive(5'b00100, {64'h0, 32'h9ABCDEF0, 64'h0}, 2, 1'b0, 0, 5'd10, 32'h3004);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin
      bad++; $display("FAIL arst_ctl: got %b/%b/%h want 0/0/0", out_valid, rf_we, debug_wb_rf_wen); end
    total++; if (rf_wdata !== 32'h0 || rf_waddr !== 5'h0 || debug_wb_pc !== 32'h0 ||
                 debug_wb_rf_wdata !== 32'h0) begin
      bad++; $display("FAIL arst_data: got %h/%h/%h/%h want 0", rf_wdata, rf_waddr, debug_wb_pc,
                      debug_wb_rf_wdata); end
    @(negedge clock);
    reset = 1'b1;
    drive(5'b01000, {32'h0, 32'h0BADF00D, 96'h0}, 2, 1'b0, 0, 5'd11, 32'h3008);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'h0BADF00D ||
                 rf_waddr !== 5'd11) begin
      bad++; $display("FAIL arst_after: got %b/%b/%h/%h want 1/1/0badf00d/b", out_valid, rf_we,
                      rf_wdata, rf_waddr); end
    tick();
  endtask

  task automatic test_dw64();
    out_ready  = 1'b1;
    x_in_valid = 1'b1;
    x_src_sel  = 5'b00001;
    x_src_data = {256'h0, 64'h0123456789ABCDEF};
    x_size     = 2'd3;
    x_signed   = 1'b0;
    x_addr_lo  = 3'd0;
    tick();
    x_in_valid = 1'b0;
    total++; if (x_out_valid !== 1'b1 || x_rf_wdata !== 64'h0123456789ABCDEF || x_rf_we !== 1'b1) begin
      bad++; $display("FAIL dw64_dword: got %b/%h/%b want 1/0123456789abcdef/1", x_out_valid,
                      x_rf_wdata, x_rf_we); end
    tick();
    x_in_valid = 1'b1;
    x_src_data = {256'h0, 64'h8000000000000000};
    x_size     = 2'd2;
    x_signed   = 1'b1;
    x_addr_lo  = 3'd4;
    tick();
    x_in_valid = 1'b0;
    total++; if (x_rf_wdata !== 64'hFFFFFFFF80000000 || x_dbg_wdata !== 64'hFFFFFFFF80000000) begin
      bad++; $display("FAIL dw64_word: got %h/%h want ffffffff80000000", x_rf_wdata, x_dbg_wdata); end
    tick();
    total++; if (x_out_valid !== 1'b0) begin bad++; $display("FAIL dw64_drain: got %b want 0", x_out_valid); end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [31:0] src [5];
    logic [63:0] ld;
    int          k, sz, off;
    bit          acc, pop, exp_we;
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 5; j++) src[j] = $urandom;
      in_src_data   = {src[4], src[3], src[2], src[1], src[0]};
      in_src_sel    = 5'($urandom_range(0, 31));
      sz            = $urandom_range(0, 2);
      off           = $urandom_range(0, 3);
      off           = off - (off % (1 << sz));
      in_mem_size   = 2'(sz);
      in_addr_lo    = 2'(off);
      in_mem_signed = 1'($urandom_range(0, 1));
      in_rf_wen     = 1'($urandom_range(0, 1));
      in_rf_waddr   = 5'($urandom_range(0, 31));
      in_pc         = $urandom;
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 29) == 0);
      #1;
      exp_we = !flush && out_ready && q.size() > 0 && q[0].wen;
      total++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        bad++; $display("FAIL rnd_hs c=%0d: got v=%b r=%b want v=%b r=%b", c, out_valid, in_ready,
                        q.size() > 0, q.size() < 2); end
      total++; if (rf_we !== exp_we || debug_wb_rf_wen !== {4{exp_we}}) begin
        bad++; $display("FAIL rnd_we c=%0d: got %b/%h want %b", c, rf_we, debug_wb_rf_wen, exp_we); end
      if (q.size() > 0) begin
        total++; if (rf_wdata !== q[0].data || debug_wb_rf_wdata !== q[0].data ||
                     rf_waddr !== q[0].waddr || debug_wb_pc !== q[0].pc) begin
          bad++; $display("FAIL rnd_head c=%0d: got %h/%h/%h want %h/%h/%h", c, rf_wdata, rf_waddr,
                          debug_wb_pc, q[0].data, q[0].waddr, q[0].pc); end
      end
      acc = in_valid && q.size() < 2;
      pop = out_ready && q.size() > 0;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          k = first_set(in_src_sel);
          ld = ref_load({32'h0, src[0]}, sz, in_mem_signed, off, 32);
          e.data  = (k < 0) ? 32'h0 : (k == 0) ? ld[31:0] : src[k];
          e.wen   = in_rf_wen;
          e.waddr = in_rf_waddr;
          e.pc    = in_pc;
          q.push_back(e);
        end
      end
      tick();
    end
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_ext();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_dw64();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
